// File: rtl/lut_pkg.sv
// Shared types and constants for the lookup-table frame loader.
package lut_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLen,
        StData,
        StChk
    } lut_state_e;

    localparam logic [1:0]  ERR_CHK      = 2'b01;
    localparam logic [1:0]  ERR_TMO      = 2'b10;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam int unsigned LUT_DEPTH    = 256;

endpackage

// File: rtl/lut_wr_stage.sv
// Single-entry holding register for the table write port; at most one write is outstanding.
module lut_wr_stage
    import lut_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              can_load
);

    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load) begin
            en_d   = 1'b1;
            addr_d = load_addr;
            data_d = load_data;
        end else if (wr_ready) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // A retiring write frees the slot in the same cycle, allowing one write per cycle.
    assign can_load = !en_q || wr_ready;
    assign wr_en    = en_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;

endmodule

// File: rtl/lut_frame_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from a byte stream and writes the data bytes into the
// lookup table at auto-incrementing addresses, reporting checksum and timeout verdicts.
module lut_frame_loader
    import lut_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lut_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [7:0]        chk_sum;
    logic              accept;
    logic              load;
    logic              stage_ready;

    lut_wr_stage #(
        .ADDR_W (ADDR_W)
    ) u_wr_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_addr (ptr_q),
        .load_data (in_byte),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .can_load  (stage_ready)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        chk_sum     = sum_q + in_byte;

        // CHK waits for the last data write to drain before the verdict.
        case (state_q)
            StData:  in_ready = stage_ready;
            StChk:   in_ready = !wr_en;
            default: in_ready = 1'b1;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end

        accept = in_valid && in_ready;
        load   = accept && (state_q == StData);

        if (accept) begin
            tmo_d = '0;
            case (state_q)
                StIdle: begin
                    if (in_byte == SYNC_BYTE) begin
                        state_d = StAddr;
                    end
                end
                StAddr: begin
                    ptr_d   = ADDR_W'(in_byte);
                    state_d = StLen;
                end
                StLen: begin
                    rem_d   = in_byte;
                    sum_d   = '0;
                    state_d = StData;
                end
                StData: begin
                    sum_d = chk_sum;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (rem_q == 8'd0) begin
                        state_d = StChk;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                StChk: begin
                    if (chk_sum == 8'd0) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && TIMEOUT != 0) begin
            if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_TMO;
                state_d     = StIdle;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            rem_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: doc/lut_frame_loader.md
Name: lut_frame_loader

Overview:
Programs the 256x8 lookup table that the design reads by address. It accepts a framed byte stream over a valid/ready handshake and checks each frame. Each data byte becomes one write on the table's write port, at auto-incrementing addresses. It sits between the host byte interface (ui_in/uio_in capture logic) and the table's write side; the read side stays combinational and is not part of this block.

Parameters:
ADDR_W, 8, table address width; addresses wrap modulo 2^ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 1024, idle cycles allowed mid-frame before abort; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  host byte valid
in_ready  out  1  block can accept in_byte this cycle
in_byte  in  8  host byte
wr_en  out  1  table write request, held until accepted
wr_ready  in  1  table accepts the write this cycle
wr_addr  out  ADDR_W  table write address
wr_data  out  8  table write data
busy  out  1  high when the FSM is not in IDLE
frame_ok  out  1  one-cycle pulse: frame complete, checksum good
frame_err  out  1  one-cycle pulse: frame aborted or checksum bad
err_code  out  2  valid with frame_err: 01 checksum, 10 timeout; holds its last value otherwise

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0 during reset, 1 in the cycle after; wr_en=0; wr_addr=0; wr_data=0; busy=0; frame_ok=0; frame_err=0; err_code=00; FSM=IDLE; checksum=0; timeout counter=0.
- A byte is accepted on a cycle where in_valid & in_ready.
- Frame format: SYNC, ADDR, LEN, LEN+1 data bytes, CHK. The frame is good when (sum of the data bytes + CHK) mod 256 == 0.
- FSM states and transitions:
  - IDLE: accepted SYNC -> ADDR. Any other accepted byte is discarded with no pulse.
  - ADDR: accepted byte loads the address pointer -> LEN.
  - LEN: accepted byte loads the remaining count = byte; clears the checksum -> DATA.
  - DATA: accepted byte is registered into wr_data/wr_addr and wr_en=1 on the next cycle. The checksum adds the byte; the pointer increments mod 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8). When the count was 0 -> CHK, else the count decrements.
  - CHK: accepted byte is added to the checksum. Result 0 -> frame_ok pulse on the next cycle, else frame_err with err_code=01. Then -> IDLE.
- in_ready: 1 in IDLE, ADDR, LEN and CHK. In DATA it equals !wr_en | wr_ready, so at most one write is outstanding. In CHK it is 0 while wr_en is pending, so the last write drains before the verdict.
- Write port: wr_en stays high with wr_addr/wr_data stable until a wr_ready cycle. The same cycle can accept a new data byte (back-to-back, 1 write per cycle at full rate).
- No rollback: table writes made before a bad checksum or timeout are not undone.
- Timeout: in ADDR, LEN, DATA or CHK, the counter increments each cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT -> frame_err with err_code=10 and FSM to IDLE. A pending wr_en still completes.
- Latency: a data byte reaches wr_en 1 cycle after acceptance. frame_ok/frame_err assert 1 cycle after CHK is accepted.
- SYNC_BYTE has no special meaning after IDLE; it is treated as ordinary ADDR/LEN/data/CHK content.
- Reset mid-frame: FSM to IDLE and wr_en drops immediately. A partial frame produces no pulse.

Decomposition:
- Shared package lut_pkg:
  - FSM state enum (IDLE, ADDR, LEN, DATA, CHK)
  - err_code constants ERR_CHK=2'b01, ERR_TMO=2'b10
  - default SYNC_BYTE
  - LUT_DEPTH=256
- One natural sub-module, lut_wr_stage: a single-entry write holding register that generates wr_en and the in_ready term for DATA. The FSM, checksum and timeout stay in the top.

Test Plan:
- Basic frame: stream A5 10 02 11 22 33 9A with wr_ready=1 -> writes (10,11) (11,22) (12,33) on consecutive cycles; frame_ok pulses once; busy falls.
- Address wrap: A5 FF 01 AA BB 9B -> writes (FF,AA) then (00,BB); frame_ok.
- Bad checksum plus leading garbage: 00 5A A5 20 00 77 00 -> garbage causes no writes and no pulses; write (20,77) occurs; frame_err with err_code=01.
- Backpressure: basic frame with wr_ready low for 3 cycles on each write -> in_ready=0 while wr_en is pending; wr_addr/wr_data stable; same three writes; frame_ok.
- Timeout: TIMEOUT=8; send A5 40 then stop -> frame_err with err_code=10 on the 8th idle cycle; FSM IDLE; a following good frame succeeds.
- Reset mid-frame: assert rst after A5 30 01 44 -> wr_en=0 and busy=0 the next cycle; no pulses; the next frame from IDLE works.
